// File: rtl/gray_pkg.sv
// gray_pkg: Gray/binary conversion helpers and handshake FSM state type
// shared by the Gray-code counter.
`default_nettype none

package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        HOLD  = 2'd2
    } gray_state_e;

    // Zero-extended operands are safe: the top Gray bit becomes b[W-1] ^ 0.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : gray_pkg

`default_nettype wire

// File: rtl/gray_code_counter.sv
// ============================================================================
// gray_code_counter: registered Gray-code up/down counter with valid/ready
// output handshake. Optional macro GRAY_SATURATE_EN clamps at the ends.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int INIT_BIN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    input  logic             g_ready,
    output logic [WIDTH-1:0] g_out,
    output logic             g_valid,
    output logic             tc
);

    localparam logic [WIDTH-1:0] C_INIT     = WIDTH'(INIT_BIN);
    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] C_ZERO     = '0;

    gray_state_e      r_state;
    gray_state_e      w_state_next;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_tc;

    logic             w_valid;
    logic             w_accept;
    logic             w_free;
    logic             w_req;
    logic             w_update;
    logic             w_at_end;
    logic [WIDTH-1:0] w_bin_next;
    logic             w_tc_next;

    // State register; bin, Gray code and tc only move on an accepted update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_bin   <= C_INIT;
            r_gray  <= WIDTH'(bin2gray(GRAY_MAX_W'(C_INIT)));
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tc    <= w_tc_next;
            if (w_update) begin
                r_bin  <= w_bin_next;
                r_gray <= WIDTH'(bin2gray(GRAY_MAX_W'(w_bin_next)));
            end
        end
    end

    // Next-state and datapath decision.
    always_comb begin
        w_accept   = w_valid & g_ready;
        w_free     = ~w_valid | w_accept;
        w_req      = load | en;
        w_update   = w_free & w_req;
        w_at_end   = up ? (r_bin == C_ALL_ONES) : (r_bin == C_ZERO);
        w_tc_next  = w_update & ~load & en & w_at_end;

        w_bin_next = r_bin;
        if (load) begin
            w_bin_next = load_bin;
        end else if (en) begin
`ifdef GRAY_SATURATE_EN
            if (!w_at_end) begin
                w_bin_next = up ? r_bin + 1'b1 : r_bin - 1'b1;
            end
`else
            w_bin_next = up ? r_bin + 1'b1 : r_bin - 1'b1;
`endif
        end

        w_state_next = IDLE;
        case (r_state)
            IDLE: begin
                w_state_next = w_req ? VALID : IDLE;
            end
            VALID, HOLD: begin
                if (!g_ready) begin
                    w_state_next = HOLD;
                end else if (w_req) begin
                    w_state_next = VALID;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs: g_out and tc come straight from flops.
    always_comb begin
        w_valid = (r_state != IDLE);
        g_valid = w_valid;
        g_out   = r_gray;
        tc      = r_tc;
    end

endmodule : gray_code_counter

`default_nettype wire

// File: tb/tb_gray_code_counter.sv
// tb_gray_code_counter: directed-vector bench for gray_code_counter (WIDTH=3, INIT_BIN=0).
`default_nettype none

module tb_gray_code_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [2:0] load_bin;
    logic       g_ready;
    logic [2:0] g_out;
    logic       g_valid;
    logic       tc;

    int n_vec;
    int n_err;

    gray_code_counter #(
        .WIDTH    (3),
        .INIT_BIN (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .g_ready  (g_ready),
        .g_out    (g_out),
        .g_valid  (g_valid),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling / re-driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_bin = 3'b000; g_ready = 1'b1;
        step();
        step();
        n_vec++;
        if (g_out !== 3'b000) begin n_err++; $display("FAIL reset_g_out got=%b exp=000", g_out); end
        n_vec++;
        if (g_valid !== 1'b0) begin n_err++; $display("FAIL reset_g_valid got=%b exp=0", g_valid); end
        n_vec++;
        if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc got=%b exp=0", tc); end
        rst = 1'b0;
        step();
        n_vec++;
        if (g_valid !== 1'b0 || g_out !== 3'b000) begin
            n_err++; $display("FAIL idle_no_req got=%b/%b exp=000/0", g_out, g_valid);
        end
    endtask

    task automatic test_up_count();
        logic [2:0] exp_g [9];
        logic       exp_tc [9];
        logic [2:0] prev;
        logic [2:0] diff;
        exp_g  = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
        exp_tc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        prev = 3'b000;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            diff = g_out ^ prev;
            n_vec++;
            if (g_out !== exp_g[i] || tc !== exp_tc[i] || g_valid !== 1'b1 || !$onehot(diff)) begin
                n_err++;
                $display("FAIL up_step%0d got g=%b tc=%b v=%b exp g=%b tc=%b v=1", i, g_out, tc, g_valid, exp_g[i], exp_tc[i]);
            end
            prev = g_out;
        end
        en = 1'b0;
        step();
        n_vec++;
        if (g_valid !== 1'b0 || g_out !== 3'b001 || tc !== 1'b0) begin
            n_err++; $display("FAIL up_to_idle got g=%b v=%b tc=%b exp 001/0/0", g_out, g_valid, tc);
        end
    endtask

    task automatic test_down_wrap();
        load = 1'b1; load_bin = 3'b000;
        step();
        load = 1'b0;
        n_vec++;
        if (g_out !== 3'b000 || tc !== 1'b0 || g_valid !== 1'b1) begin
            n_err++; $display("FAIL load_zero got g=%b tc=%b v=%b exp 000/0/1", g_out, tc, g_valid);
        end
        en = 1'b1; up = 1'b0;
        step();
        n_vec++;
        if (g_out !== 3'b100 || tc !== 1'b1) begin
            n_err++; $display("FAIL down_wrap got g=%b tc=%b exp 100/1", g_out, tc);
        end
        step();
        n_vec++;
        if (g_out !== 3'b101 || tc !== 1'b0) begin
            n_err++; $display("FAIL down_step got g=%b tc=%b exp 101/0", g_out, tc);
        end
        en = 1'b0; up = 1'b1;
        step();
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_bin = 3'b101; en = 1'b1; up = 1'b1;
        step();
        load = 1'b0; en = 1'b0;
        n_vec++;
        if (g_out !== 3'b111 || tc !== 1'b0 || g_valid !== 1'b1) begin
            n_err++; $display("FAIL load_prio got g=%b tc=%b v=%b exp 111/0/1", g_out, tc, g_valid);
        end
        step();
    endtask

    task automatic test_stall();
        load = 1'b1; load_bin = 3'b010;
        step();
        load = 1'b0;
        n_vec++;
        if (g_out !== 3'b011 || g_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_setup got g=%b v=%b exp 011/1", g_out, g_valid);
        end
        g_ready = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load = (i == 2);
            load_bin = 3'b110;
            step();
            n_vec++;
            if (g_out !== 3'b011 || g_valid !== 1'b1 || tc !== 1'b0) begin
                n_err++; $display("FAIL stall_hold%0d got g=%b v=%b tc=%b exp 011/1/0", i, g_out, g_valid, tc);
            end
        end
        load = 1'b0;
        g_ready = 1'b1;
        step();
        n_vec++;
        if (g_out !== 3'b010 || g_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_release got g=%b v=%b exp 010/1", g_out, g_valid);
        end
        en = 1'b0;
        step();
        n_vec++;
        if (g_out !== 3'b010 || g_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_drain got g=%b v=%b exp 010/0", g_out, g_valid);
        end
    endtask

    task automatic test_mid_reset();
        load = 1'b1; load_bin = 3'b110;
        step();
        load = 1'b0; g_ready = 1'b0; en = 1'b1;
        step();
        rst = 1'b1;
        step();
        n_vec++;
        if (g_out !== 3'b000 || g_valid !== 1'b0 || tc !== 1'b0) begin
            n_err++; $display("FAIL mid_reset got g=%b v=%b tc=%b exp 000/0/0", g_out, g_valid, tc);
        end
        rst = 1'b0; g_ready = 1'b1; en = 1'b0;
        step();
    endtask

    task automatic test_top_end();
        load = 1'b1; load_bin = 3'b111;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        en = 1'b0;
`ifdef GRAY_SATURATE_EN
        n_vec++;
        if (g_out !== 3'b100 || tc !== 1'b1 || g_valid !== 1'b1) begin
            n_err++; $display("FAIL saturate_up got g=%b tc=%b v=%b exp 100/1/1", g_out, tc, g_valid);
        end
`else
        n_vec++;
        if (g_out !== 3'b000 || tc !== 1'b1 || g_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_up got g=%b tc=%b v=%b exp 000/1/1", g_out, tc, g_valid);
        end
`endif
        step();
        n_vec++;
        if (tc !== 1'b0 || g_valid !== 1'b0) begin
            n_err++; $display("FAIL tc_pulse got tc=%b v=%b exp 0/0", tc, g_valid);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_up_count();
        test_down_wrap();
        test_load_priority();
        test_stall();
        test_mid_reset();
        test_top_end();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_gray_code_counter

`default_nettype wire
